// File: rtl/prbs_pkg.sv
// -----------------------------------------------------------------------------
// prbs_pkg
// Shared types and helpers for the PRBS stream checker.
//   state_e      : checker FSM states
//   prbs_mode_e  : polynomial select encoding (PRBS7/15/23/31)
//   PrbsXLen/Tap : LFSR length and second tap per polynomial
//   seed_bytes() : whole bytes needed to fill an LFSR of the selected length
//   lfsr_mask()  : mask of the live LFSR bits for the selected length
//   popcount8()  : number of set bits in a byte
// -----------------------------------------------------------------------------
package prbs_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StPat,
      StSeed,
      StCheck,
      StFail
   } state_e;

   typedef enum logic [1:0] {
      ModePrbs7  = 2'd0,
      ModePrbs15 = 2'd1,
      ModePrbs23 = 2'd2,
      ModePrbs31 = 2'd3
   } prbs_mode_e;

   localparam int unsigned LfsrW = 31;

   localparam int unsigned Prbs7Len  = 7;
   localparam int unsigned Prbs7Tap  = 6;
   localparam int unsigned Prbs15Len = 15;
   localparam int unsigned Prbs15Tap = 14;
   localparam int unsigned Prbs23Len = 23;
   localparam int unsigned Prbs23Tap = 18;
   localparam int unsigned Prbs31Len = 31;
   localparam int unsigned Prbs31Tap = 28;

   // ceil(L/8): bytes of received data needed to fully overwrite the LFSR.
   function automatic logic [2:0] seed_bytes(input prbs_mode_e mode);
      logic [2:0] cnt;
      unique case (mode)
         ModePrbs7:  cnt = 3'd1;
         ModePrbs15: cnt = 3'd2;
         ModePrbs23: cnt = 3'd3;
         ModePrbs31: cnt = 3'd4;
         default:    cnt = 3'd4;
      endcase
      return cnt;
   endfunction

   function automatic logic [LfsrW-1:0] lfsr_mask(input prbs_mode_e mode);
      logic [LfsrW-1:0] m;
      unique case (mode)
         ModePrbs7:  m = 31'h0000_007F;
         ModePrbs15: m = 31'h0000_7FFF;
         ModePrbs23: m = 31'h007F_FFFF;
         ModePrbs31: m = 31'h7FFF_FFFF;
         default:    m = 31'h7FFF_FFFF;
      endcase
      return m;
   endfunction

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] cnt;
      cnt = 4'd0;
      for (int i = 0; i < 8; i++) begin
         cnt = cnt + {3'd0, v[i]};
      end
      return cnt;
   endfunction

endpackage

// File: rtl/prbs_lfsr_byte.sv
// -----------------------------------------------------------------------------
// prbs_lfsr_byte
// Byte-wide Fibonacci LFSR for the selected PRBS polynomial.
//   clk       : system clock, rising edge
//   rst       : synchronous active-low reset (clears the LFSR)
//   clear_i   : clear the LFSR to zero
//   load_i    : shift data_i into the LFSR, bit 0 first (self-sync seeding)
//   advance_i : free-run the LFSR by 8 bits
//   mode_i    : polynomial select
//   data_i    : received byte used when loading
//   pred_o    : next 8 LFSR output bits from the current state, bit 0 first
// -----------------------------------------------------------------------------
module prbs_lfsr_byte
   import prbs_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clear_i,
   input  logic       load_i,
   input  logic       advance_i,
   input  prbs_mode_e mode_i,
   input  logic [7:0] data_i,
   output logic [7:0] pred_o
);

   logic [LfsrW-1:0] state_q, state_d;
   logic [LfsrW-1:0] step;
   logic [7:0]       pred;
   logic             fb;
   logic             nb;

   // Eight serial steps unrolled; the feedback bit is both the predicted
   // output and, unless loading, the bit shifted back in.
   always_comb begin
      step = state_q;
      pred = 8'd0;
      fb   = 1'b0;
      nb   = 1'b0;
      for (int i = 0; i < 8; i++) begin
         unique case (mode_i)
            ModePrbs7:  fb = step[Prbs7Len-1]  ^ step[Prbs7Tap-1];
            ModePrbs15: fb = step[Prbs15Len-1] ^ step[Prbs15Tap-1];
            ModePrbs23: fb = step[Prbs23Len-1] ^ step[Prbs23Tap-1];
            ModePrbs31: fb = step[Prbs31Len-1] ^ step[Prbs31Tap-1];
            default:    fb = step[Prbs31Len-1] ^ step[Prbs31Tap-1];
         endcase
         nb      = load_i ? data_i[i] : fb;
         pred[i] = fb;
         step    = {step[LfsrW-2:0], nb} & lfsr_mask(mode_i);
      end
   end

   always_comb begin
      state_d = state_q;
      if (clear_i) begin
         state_d = '0;
      end else if (load_i || advance_i) begin
         state_d = step;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= '0;
      end else begin
         state_q <= state_d;
      end
   end

   assign pred_o = pred;

endmodule

// File: rtl/prbs_stream_checker.sv
// -----------------------------------------------------------------------------
// prbs_stream_checker
// Receive-side checker: verifies a repeated preamble, then self-synchronises
// to a PRBS polynomial and counts bit/byte errors.
//   clk           : system clock, rising edge
//   rst           : synchronous active-low reset
//   enable        : freezes all state when low
//   n             : preamble repetitions (sampled on IDLE exit)
//   pattern       : preamble, byte 0 in [7:0] arrives first (sampled on IDLE exit)
//   prbs_mode     : 0=PRBS7 1=PRBS15 2=PRBS23 3=PRBS31 (sampled on IDLE exit)
//   byte_in       : received byte
//   byte_valid    : byte_in valid this cycle
//   pattern_valid : preamble matched n times (sticky)
//   pattern_error : preamble mismatch (sticky)
//   prbs_lock     : PRBS checker locked
//   bit_err_cnt   : saturating errored-bit count in CHECK
//   byte_err_cnt  : saturating errored-byte count in CHECK
// -----------------------------------------------------------------------------
module prbs_stream_checker
   import prbs_pkg::*;
#(
   parameter int unsigned PATTERN_BYTES = 4,
   parameter int unsigned N_WIDTH       = 8,
   parameter int unsigned CNT_WIDTH     = 16,
   parameter int unsigned LOCK_CNT      = 8,
   parameter int unsigned LOSS_CNT      = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enable,
   input  logic [N_WIDTH-1:0]         n,
   input  logic [8*PATTERN_BYTES-1:0] pattern,
   input  logic [1:0]                 prbs_mode,
   input  logic [7:0]                 byte_in,
   input  logic                       byte_valid,
   output logic                       pattern_valid,
   output logic                       pattern_error,
   output logic                       prbs_lock,
   output logic [CNT_WIDTH-1:0]       bit_err_cnt,
   output logic [CNT_WIDTH-1:0]       byte_err_cnt
);

   localparam int unsigned IdxW   = (PATTERN_BYTES > 1) ? $clog2(PATTERN_BYTES) : 1;
   localparam int unsigned RunMax = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
   localparam int unsigned RunW   = $clog2(RunMax + 1);
   localparam int unsigned SumW   = CNT_WIDTH + 1;

   state_e                     state_q, state_d;
   logic [N_WIDTH-1:0]         n_q, n_d;
   logic [8*PATTERN_BYTES-1:0] pattern_q, pattern_d;
   prbs_mode_e                 mode_q, mode_d;
   logic [IdxW-1:0]            byte_idx_q, byte_idx_d;
   logic [N_WIDTH-1:0]         rep_q, rep_d;
   logic [2:0]                 seed_cnt_q, seed_cnt_d;
   logic [RunW-1:0]            good_run_q, good_run_d;
   logic [RunW-1:0]            bad_run_q, bad_run_d;
   logic                       pattern_valid_q, pattern_valid_d;
   logic                       pattern_error_q, pattern_error_d;
   logic                       prbs_lock_q, prbs_lock_d;
   logic [CNT_WIDTH-1:0]       bit_err_cnt_q, bit_err_cnt_d;
   logic [CNT_WIDTH-1:0]       byte_err_cnt_q, byte_err_cnt_d;

   logic                       lfsr_clear, lfsr_load, lfsr_adv;
   logic [7:0]                 lfsr_pred;
   logic [7:0]                 exp_byte;
   logic [7:0]                 diff;
   logic [SumW-1:0]            bit_sum;
   logic [CNT_WIDTH-1:0]       bit_err_sat;
   logic [CNT_WIDTH-1:0]       byte_err_sat;
   logic [RunW-1:0]            good_inc, bad_inc;

   prbs_lfsr_byte u_lfsr (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (lfsr_clear),
      .load_i    (lfsr_load),
      .advance_i (lfsr_adv),
      .mode_i    (mode_q),
      .data_i    (byte_in),
      .pred_o    (lfsr_pred)
   );

   always_comb begin
      exp_byte = 8'd0;
      for (int i = 0; i < PATTERN_BYTES; i++) begin
         if (byte_idx_q == IdxW'(i)) begin
            exp_byte = pattern_q[8*i +: 8];
         end
      end
   end

   // Error datapath; the extra sum bit catches counter overflow for saturation.
   always_comb begin
      diff         = byte_in ^ lfsr_pred;
      bit_sum      = {1'b0, bit_err_cnt_q} + SumW'(popcount8(diff));
      bit_err_sat  = bit_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : bit_sum[CNT_WIDTH-1:0];
      byte_err_sat = (byte_err_cnt_q == {CNT_WIDTH{1'b1}}) ? byte_err_cnt_q
                                                           : byte_err_cnt_q + 1'b1;
      good_inc     = good_run_q + RunW'(1);
      bad_inc      = bad_run_q + RunW'(1);
   end

   always_comb begin
      state_d         = state_q;
      n_d             = n_q;
      pattern_d       = pattern_q;
      mode_d          = mode_q;
      byte_idx_d      = byte_idx_q;
      rep_d           = rep_q;
      seed_cnt_d      = seed_cnt_q;
      good_run_d      = good_run_q;
      bad_run_d       = bad_run_q;
      pattern_valid_d = pattern_valid_q;
      pattern_error_d = pattern_error_q;
      prbs_lock_d     = prbs_lock_q;
      bit_err_cnt_d   = bit_err_cnt_q;
      byte_err_cnt_d  = byte_err_cnt_q;
      lfsr_clear      = 1'b0;
      lfsr_load       = 1'b0;
      lfsr_adv        = 1'b0;

      if (enable) begin
         unique case (state_q)
            StIdle: begin
               n_d            = n;
               pattern_d      = pattern;
               mode_d         = prbs_mode_e'(prbs_mode);
               bit_err_cnt_d  = '0;
               byte_err_cnt_d = '0;
               byte_idx_d     = '0;
               rep_d          = '0;
               seed_cnt_d     = 3'd0;
               good_run_d     = '0;
               bad_run_d      = '0;
               lfsr_clear     = 1'b1;
               if (n == '0) begin
                  pattern_valid_d = 1'b1;
                  state_d         = StSeed;
               end else begin
                  state_d = StPat;
               end
            end

            StPat: begin
               if (byte_valid) begin
                  if (byte_in != exp_byte) begin
                     pattern_error_d = 1'b1;
                     state_d         = StFail;
                  end else if (byte_idx_q == IdxW'(PATTERN_BYTES - 1)) begin
                     byte_idx_d = '0;
                     if (rep_q == n_q - N_WIDTH'(1)) begin
                        pattern_valid_d = 1'b1;
                        state_d         = StSeed;
                     end else begin
                        rep_d = rep_q + N_WIDTH'(1);
                     end
                  end else begin
                     byte_idx_d = byte_idx_q + IdxW'(1);
                  end
               end
            end

            StSeed: begin
               if (byte_valid) begin
                  lfsr_load = 1'b1;
                  if (seed_cnt_q + 3'd1 == seed_bytes(mode_q)) begin
                     seed_cnt_d = 3'd0;
                     state_d    = StCheck;
                  end else begin
                     seed_cnt_d = seed_cnt_q + 3'd1;
                  end
               end
            end

            StCheck: begin
               if (byte_valid) begin
                  lfsr_adv = 1'b1;
                  if (diff == 8'd0) begin
                     bad_run_d = '0;
                     // Hold the good run at the lock threshold once reached.
                     if (good_run_q != RunW'(LOCK_CNT)) begin
                        good_run_d = good_inc;
                     end
                     if (good_inc == RunW'(LOCK_CNT)) begin
                        prbs_lock_d = 1'b1;
                     end
                  end else begin
                     good_run_d     = '0;
                     bit_err_cnt_d  = bit_err_sat;
                     byte_err_cnt_d = byte_err_sat;
                     if (bad_inc == RunW'(LOSS_CNT)) begin
                        prbs_lock_d = 1'b0;
                        bad_run_d   = '0;
                        seed_cnt_d  = 3'd0;
                        state_d     = StSeed;
                     end else begin
                        bad_run_d = bad_inc;
                     end
                  end
               end
            end

            StFail: begin
               state_d = StFail;
            end

            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q         <= StIdle;
         n_q             <= '0;
         pattern_q       <= '0;
         mode_q          <= ModePrbs7;
         byte_idx_q      <= '0;
         rep_q           <= '0;
         seed_cnt_q      <= 3'd0;
         good_run_q      <= '0;
         bad_run_q       <= '0;
         pattern_valid_q <= 1'b0;
         pattern_error_q <= 1'b0;
         prbs_lock_q     <= 1'b0;
         bit_err_cnt_q   <= '0;
         byte_err_cnt_q  <= '0;
      end else begin
         state_q         <= state_d;
         n_q             <= n_d;
         pattern_q       <= pattern_d;
         mode_q          <= mode_d;
         byte_idx_q      <= byte_idx_d;
         rep_q           <= rep_d;
         seed_cnt_q      <= seed_cnt_d;
         good_run_q      <= good_run_d;
         bad_run_q       <= bad_run_d;
         pattern_valid_q <= pattern_valid_d;
         pattern_error_q <= pattern_error_d;
         prbs_lock_q     <= prbs_lock_d;
         bit_err_cnt_q   <= bit_err_cnt_d;
         byte_err_cnt_q  <= byte_err_cnt_d;
      end
   end

   assign pattern_valid = pattern_valid_q;
   assign pattern_error = pattern_error_q;
   assign prbs_lock     = prbs_lock_q;
   assign bit_err_cnt   = bit_err_cnt_q;
   assign byte_err_cnt  = byte_err_cnt_q;

endmodule

// File: tb/tb_prbs_stream_checker.sv
// -----------------------------------------------------------------------------
// tb_prbs_stream_checker
// Two checkers share one input stream: dut_a with 16-bit counters and dut_b
// with 4-bit counters. Stimulus pushes expected outputs into a scoreboard
// queue; a monitor on the falling edge pops and compares both instances.
// -----------------------------------------------------------------------------
module tb_prbs_stream_checker;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [7:0]  n;
   logic [31:0] pattern;
   logic [1:0]  prbs_mode;
   logic [7:0]  byte_in;
   logic        byte_valid;

   logic        pv_a, pe_a, lk_a;
   logic [15:0] bit_a, byte_a;
   logic        pv_b, pe_b, lk_b;
   logic [3:0]  bit_b, byte_b;

   always #5 clk = ~clk;

   prbs_stream_checker dut_a (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .n             (n),
      .pattern       (pattern),
      .prbs_mode     (prbs_mode),
      .byte_in       (byte_in),
      .byte_valid    (byte_valid),
      .pattern_valid (pv_a),
      .pattern_error (pe_a),
      .prbs_lock     (lk_a),
      .bit_err_cnt   (bit_a),
      .byte_err_cnt  (byte_a)
   );

   prbs_stream_checker #(.CNT_WIDTH(4)) dut_b (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .n             (n),
      .pattern       (pattern),
      .prbs_mode     (prbs_mode),
      .byte_in       (byte_in),
      .byte_valid    (byte_valid),
      .pattern_valid (pv_b),
      .pattern_error (pe_b),
      .prbs_lock     (lk_b),
      .bit_err_cnt   (bit_b),
      .byte_err_cnt  (byte_b)
   );

   typedef struct {
      string name;
      bit    pv;
      bit    pe;
      bit    lock;
      int    bits;
      int    bytes;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          errors = 0;
   int          checks = 0;
   bit          exp_pv, exp_pe, exp_lock;
   int          exp_bits, exp_bytes;
   int unsigned g_state, g_len, g_tap;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   function automatic int sat(input int v, input int maxv);
      return (v > maxv) ? maxv : v;
   endfunction

   // Monitor: outputs are registered, so the falling edge is a stable point.
   always @(negedge clk) begin
      while (sb.size() > 0) begin
         mon_e = sb.pop_front();
         chk({mon_e.name, " a.pattern_valid"}, int'(pv_a), int'(mon_e.pv));
         chk({mon_e.name, " a.pattern_error"}, int'(pe_a), int'(mon_e.pe));
         chk({mon_e.name, " a.prbs_lock"}, int'(lk_a), int'(mon_e.lock));
         chk({mon_e.name, " a.bit_err_cnt"}, int'(bit_a), sat(mon_e.bits, 65535));
         chk({mon_e.name, " a.byte_err_cnt"}, int'(byte_a), sat(mon_e.bytes, 65535));
         chk({mon_e.name, " b.pattern_valid"}, int'(pv_b), int'(mon_e.pv));
         chk({mon_e.name, " b.pattern_error"}, int'(pe_b), int'(mon_e.pe));
         chk({mon_e.name, " b.prbs_lock"}, int'(lk_b), int'(mon_e.lock));
         chk({mon_e.name, " b.bit_err_cnt"}, int'(bit_b), sat(mon_e.bits, 15));
         chk({mon_e.name, " b.byte_err_cnt"}, int'(byte_b), sat(mon_e.bytes, 15));
      end
   end

   task automatic expect_now(input string name);
      exp_t e;
      e.name  = name;
      e.pv    = exp_pv;
      e.pe    = exp_pe;
      e.lock  = exp_lock;
      e.bits  = exp_bits;
      e.bytes = exp_bytes;
      sb.push_back(e);
   endtask

   // Reference PRBS generator: output bit = feedback bit, bit 0 first.
   task automatic gen(output logic [7:0] b);
      int unsigned nb;
      for (int i = 0; i < 8; i++) begin
         nb      = ((g_state >> (g_len - 1)) ^ (g_state >> (g_tap - 1))) & 32'd1;
         g_state = ((g_state << 1) | nb) & ((32'd1 << g_len) - 32'd1);
         b[i]    = nb[0];
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      byte_in    = b;
      byte_valid = 1'b1;
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
   endtask

   task automatic send_golden(input int count);
      logic [7:0] b;
      for (int i = 0; i < count; i++) begin
         gen(b);
         send(b);
      end
   endtask

   // Corrupt golden data; only call while the checker is in CHECK.
   task automatic send_flip(input logic [7:0] mask);
      logic [7:0] b;
      gen(b);
      send(b ^ mask);
      exp_bits  += $countones(mask);
      exp_bytes += 1;
   endtask

   task automatic pause(input int cycles);
      @(negedge clk);
      enable     = 1'b0;
      byte_valid = 1'b1;
      byte_in    = 8'hA5;
      repeat (cycles) @(posedge clk);
      #1;
      enable     = 1'b1;
      byte_valid = 1'b0;
   endtask

   task automatic gap(input int cycles);
      @(negedge clk);
      byte_valid = 1'b0;
      byte_in    = 8'h3C;
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [31:0] pat, input logic [7:0] nn, input logic [1:0] mode);
      @(negedge clk);
      rst        = 1'b0;
      enable     = 1'b1;
      byte_valid = 1'b0;
      @(posedge clk);
      #1;
      exp_pv    = 1'b0;
      exp_pe    = 1'b0;
      exp_lock  = 1'b0;
      exp_bits  = 0;
      exp_bytes = 0;
      expect_now("reset");
      pattern   = pat;
      n         = nn;
      prbs_mode = mode;
      case (mode)
         2'd0:    begin g_len = 7;  g_tap = 6;  end
         2'd1:    begin g_len = 15; g_tap = 14; end
         2'd2:    begin g_len = 23; g_tap = 18; end
         default: begin g_len = 31; g_tap = 28; end
      endcase
      g_state = 32'h5A3C_96E1 & ((32'd1 << g_len) - 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      exp_pv = (nn == 8'd0);
      expect_now("idle_exit");
   endtask

   initial begin
      logic [7:0] pb[4];
      logic [7:0] b;
      int         k;
      pb[0] = 8'h1E; pb[1] = 8'h49; pb[2] = 8'hCF; pb[3] = 8'h3A;
      rst = 1'b0; enable = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
      n = 8'd0; pattern = 32'd0; prbs_mode = 2'd0;

      // Preamble pass (with a gap and an enable pause), then PRBS15 lock.
      start(32'h3ACF491E, 8'd2, 2'd1);
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 4; i++) begin
            send(pb[i]);
            if (r == 1 && i == 3) exp_pv = 1'b1;
            expect_now($sformatf("pre_r%0d_b%0d", r, i));
            if (r == 0 && i == 2) gap(2);
            if (r == 1 && i == 0) begin
               pause(3);
               expect_now("pre_pause");
            end
         end
      end
      send_golden(2);
      expect_now("p15_seeded");
      send_golden(7);
      expect_now("p15_7clean");
      send_golden(1);
      exp_lock = 1'b1;
      expect_now("p15_lock");
      // Single-bit error on the 20th CHECK byte.
      send_golden(11);
      send_flip(8'h08);
      expect_now("p15_single_err");
      send_golden(5);
      expect_now("p15_after_err");

      // Loss of lock and resync in PRBS15.
      start(32'd0, 8'd0, 2'd1);
      send_golden(10);
      exp_lock = 1'b1;
      expect_now("loss_lock");
      for (int i = 0; i < 3; i++) send_flip(8'hFF);
      expect_now("loss_3bad");
      send_flip(8'hFF);
      exp_lock = 1'b0;
      expect_now("loss_4bad");
      send_golden(9);
      expect_now("resync_7clean");
      send_golden(1);
      exp_lock = 1'b1;
      expect_now("resync_lock");

      // PRBS7: repeated loss until both small counters saturate.
      start(32'd0, 8'd0, 2'd0);
      for (int r = 0; r < 4; r++) begin
         send_golden(9);
         exp_lock = 1'b1;
         expect_now($sformatf("p7_lock_r%0d", r));
         for (int i = 0; i < 3; i++) send_flip(8'hFF);
         expect_now($sformatf("p7_3bad_r%0d", r));
         send_flip(8'hFF);
         exp_lock = 1'b0;
         expect_now($sformatf("p7_loss_r%0d", r));
      end

      // PRBS31 with gaps and pauses, including mid-seed, then mid-CHECK reset.
      start(32'd0, 8'd0, 2'd3);
      send_golden(1);
      pause(3);
      send_golden(1);
      gap(2);
      send_golden(2);
      expect_now("p31_seeded");
      for (int i = 0; i < 8; i++) begin
         send_golden(1);
         if (i == 3) gap(3);
         if (i == 5) pause(2);
      end
      exp_lock = 1'b1;
      expect_now("p31_lock");
      send_flip(8'hFF);
      pause(2);
      send_flip(8'hFF);
      gap(1);
      send_flip(8'hFF);
      expect_now("p31_3bad");
      send_flip(8'hFF);
      exp_lock = 1'b0;
      expect_now("p31_loss");
      send_golden(12);
      exp_lock = 1'b1;
      expect_now("p31_relock");
      // Reset while a valid errored byte is presented: reset wins.
      gen(b);
      @(negedge clk);
      rst        = 1'b0;
      byte_in    = b ^ 8'hFF;
      byte_valid = 1'b1;
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
      exp_pv = 1'b0; exp_lock = 1'b0; exp_bits = 0; exp_bytes = 0;
      expect_now("mid_reset");

      // Preamble failure: FAIL is terminal, PRBS data is ignored.
      start(32'h3ACF491E, 8'd2, 2'd1);
      for (int i = 0; i < 4; i++) send(pb[i]);
      expect_now("fail_rep0");
      send(8'h8B);
      exp_pe = 1'b1;
      expect_now("fail_mismatch");
      send_golden(20);
      for (int i = 0; i < 6; i++) begin
         gen(b);
         send(b ^ 8'hFF);
      end
      send(8'h1E);
      expect_now("fail_sticky");

      k = 0;
      while (sb.size() > 0 && k < 20) begin
         @(posedge clk);
         k++;
      end
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
